umi_tx_arbiter: RTL and testbench

- Round-robin arbiter sharing one 256-bit UMI TX port among N requesters (core, DMA, debug, and similar sources).
- Sits between the requesters and the UMI TX interface that the testbench drains with a valid/ready handshake.
- Holds the granted packet in a single output register. Sustains one packet per cycle when the consumer keeps out_ready high.
- Keeps a transfer counter for performance measurement.

---
 rtl/umi_tx_arbiter.sv | 167 ++++++++++++++++
 tb/tb_umi_tx_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/umi_tx_arbiter.sv
// umi_tx_arbiter
// --------------
// A round-robin arbiter that lets N requesters share one UMI TX port.
// The winning packet is loaded into a single output register. The register
// can drain and refill on the same edge, so it sustains one packet per cycle
// while the consumer holds out_ready high. A free-running counter records
// how many packets have left on the output.
//
// Parameters
//   N          number of requesters (1..16)
//   DW         packet width in bits
//   CW         width of the transfer counter
//
// Ports
//   clk        rising-edge clock
//   nreset     asynchronous active-low reset
//   in_packet  requester packets; requester i occupies [(i+1)*DW-1 : i*DW]
//   in_valid   per-requester packet valid
//   in_ready   per-requester accept (one-hot or zero)
//   req_mask   1 = requester may be granted
//   out_packet registered packet to UMI TX
//   out_valid  out_packet holds a packet
//   out_ready  UMI TX accepts out_packet
//   grant_id   requester index of the packet in out_packet
//   xfer_count number of completed output transfers (wraps)

module umi_tx_arbiter #(
    parameter int N  = 4,
    parameter int DW = 256,
    parameter int CW = 32
) (
    input  logic                                clk,
    input  logic                                nreset,
    input  logic [N*DW-1:0]                     in_packet,
    input  logic [N-1:0]                        in_valid,
    output logic [N-1:0]                        in_ready,
    input  logic [N-1:0]                        req_mask,
    output logic [DW-1:0]                       out_packet,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_id,
    output logic [CW-1:0]                       xfer_count
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    // Output register occupancy.
    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic          state_q, state_d;
    logic [DW-1:0] out_packet_q, out_packet_d;
    logic [IW-1:0] grant_id_q, grant_id_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] xfer_count_q, xfer_count_d;

    logic [N-1:0]  eligible;
    logic          any_eligible;
    logic [IW-1:0] winner;
    logic          winner_found;
    logic [IW:0]   cand_sum;
    logic [DW-1:0] sel_packet;
    logic          can_load;
    logic          load_en;
    logic          drain_en;

    assign eligible     = in_valid & req_mask;
    assign any_eligible = |eligible;

    assign out_valid  = (state_q == ST_FULL);
    assign out_packet = out_packet_q;
    assign grant_id   = grant_id_q;
    assign xfer_count = xfer_count_q;

    // Round-robin search starting at ptr_q. The candidate index is ptr_q + k
    // folded back into 0..N-1 with a single subtract, which also works when
    // N is not a power of two. The extra bit in cand_sum holds the carry.
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        cand_sum     = '0;
        for (int k = 0; k < N; k++) begin
            cand_sum = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand_sum >= (IW+1)'(N)) begin
                cand_sum = cand_sum - (IW+1)'(N);
            end
            if (!winner_found && eligible[cand_sum[IW-1:0]]) begin
                winner_found = 1'b1;
                winner       = cand_sum[IW-1:0];
            end
        end
    end

    // Pick the winning requester's slice out of the packed input bus.
    always_comb begin
        sel_packet = '0;
        for (int i = 0; i < N; i++) begin
            if (winner == IW'(i)) begin
                sel_packet = in_packet[i*DW +: DW];
            end
        end
    end

    // The register can take a new packet when it is empty, or when it is
    // full and being drained on this same edge. The out_ready term only
    // reaches in_ready; the register outputs are driven from flops alone.
    // nreset gates the accept so that no requester sees in_ready while the
    // block is held in reset.
    assign can_load = (state_q == ST_EMPTY) || out_ready;
    assign load_en  = nreset && can_load && any_eligible;
    assign drain_en = (state_q == ST_FULL) && out_ready;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = load_en && (winner == IW'(i));
        end
    end

    // Next-state for the output register and the round-robin pointer.
    // A load has priority over a plain drain, which is what makes the
    // drain-and-refill case keep out_valid high with the new packet.
    always_comb begin
        state_d      = state_q;
        out_packet_d = out_packet_q;
        grant_id_d   = grant_id_q;
        ptr_d        = ptr_q;
        if (load_en) begin
            state_d      = ST_FULL;
            out_packet_d = sel_packet;
            grant_id_d   = winner;
            if (winner == IW'(N-1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = winner + 1'b1;
            end
        end else if (drain_en) begin
            state_d = ST_EMPTY;
        end
    end

    // Transfer counter wraps naturally at 2^CW.
    always_comb begin
        xfer_count_d = xfer_count_q;
        if (drain_en) begin
            xfer_count_d = xfer_count_q + CW'(1);
        end
    end

    // All state clears asynchronously, discarding any packet in flight.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= ST_EMPTY;
            out_packet_q <= '0;
            grant_id_q   <= '0;
            ptr_q        <= '0;
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            out_packet_q <= out_packet_d;
            grant_id_q   <= grant_id_d;
            ptr_q        <= ptr_d;
            xfer_count_q <= xfer_count_d;
        end
    end

endmodule

// File: tb/tb_umi_tx_arbiter.sv
// tb_umi_tx_arbiter
// -----------------
// Drives the arbiter with directed phases followed by random traffic. A
// reference model keeps the round-robin pointer as a plain integer and the
// output register as a valid flag, packet and source index, and predicts
// every output from the arbitration rules.

module tb_umi_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 256;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            nreset;
    logic [N*DW-1:0] in_packet;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N-1:0]    req_mask;
    logic [DW-1:0]   out_packet;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      grant_id;
    logic [CW-1:0]   xfer_count;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [DW-1:0] pkt [N];
    int            m_ptr;
    logic          m_valid;
    logic [DW-1:0] m_pkt;
    int            m_gid;
    int            m_count;

    umi_tx_arbiter #(.N(N), .DW(DW), .CW(CW)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .in_packet  (in_packet),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .req_mask   (req_mask),
        .out_packet (out_packet),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .grant_id   (grant_id),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_pkt   = '0;
        m_gid   = 0;
        m_count = 0;
    endtask

    // One clock cycle: check the registered outputs at the falling edge,
    // drive new inputs, check the combinational accept, then advance the
    // model to what the next rising edge must produce.
    task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] m,
                                 input logic r, input bit directed);
        logic [N-1:0] elig;
        logic [N-1:0] exp_rdy;
        bit           can_load;
        int           w;
        int           idx;
        logic [7:0]   b;

        @(negedge clk);
        checkOutput("out_valid", 256'(out_valid), 256'(m_valid));
        checkOutput("out_packet", out_packet, m_pkt);
        checkOutput("grant_id", 256'(grant_id), 256'(m_gid));
        checkOutput("xfer_count", 256'(xfer_count), 256'(m_count));

        for (int i = 0; i < N; i++) begin
            if (directed) begin
                b      = 8'(8'hA0 + i);
                pkt[i] = {32{b}};
            end else begin
                for (int j = 0; j < DW/32; j++) begin
                    pkt[i][j*32 +: 32] = $urandom;
                end
            end
            in_packet[i*DW +: DW] = pkt[i];
        end
        in_valid  = v;
        req_mask  = m;
        out_ready = r;
        #1;

        elig     = v & m;
        can_load = !m_valid || r;
        w        = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (w < 0 && elig[idx]) begin
                w = idx;
            end
        end
        exp_rdy = '0;
        if (can_load && w >= 0) begin
            exp_rdy[w] = 1'b1;
        end
        checkOutput("in_ready", 256'(in_ready), 256'(exp_rdy));

        if (m_valid && r) begin
            m_count = (m_count + 1) % (1 << CW);
        end
        if (can_load && w >= 0) begin
            m_pkt   = pkt[w];
            m_gid   = w;
            m_valid = 1'b1;
            m_ptr   = (w + 1) % N;
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        logic [N-1:0] rv;
        logic [N-1:0] rm;
        logic         rr;

        // Reset held with every requester asking.
        nreset    = 1'b0;
        in_valid  = '1;
        req_mask  = '1;
        out_ready = 1'b0;
        in_packet = '0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 256'(out_valid), 256'(0));
        checkOutput("reset_in_ready", 256'(in_ready), 256'(0));
        checkOutput("reset_xfer_count", 256'(xfer_count), 256'(0));
        @(negedge clk);
        in_valid = '0;
        nreset   = 1'b1;

        // Full round-robin with all requesters valid and no backpressure.
        repeat (6) applyStimulus('1, '1, 1'b1, 1'b1);

        // Backpressure for three cycles, then release with no bubble.
        repeat (3) applyStimulus('1, '1, 1'b0, 1'b1);
        repeat (2) applyStimulus('1, '1, 1'b1, 1'b1);

        // Masking: only requesters 1 and 3 may win.
        repeat (5) applyStimulus('1, 4'b1010, 1'b1, 1'b1);

        // Sparse request: grant 2 moves ptr to 3, next search wraps to 2.
        repeat (2) applyStimulus(4'b0100, '1, 1'b1, 1'b0);

        // Mask cleared entirely: register drains, nothing granted.
        repeat (2) applyStimulus('1, '0, 1'b1, 1'b0);

        // Reset while a packet is held under backpressure.
        applyStimulus('1, '1, 1'b0, 1'b0);
        applyStimulus('0, '1, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        nreset = 1'b0;
        #1;
        checkOutput("async_reset_out_valid", 256'(out_valid), 256'(0));
        checkOutput("async_reset_xfer_count", 256'(xfer_count), 256'(0));
        checkOutput("async_reset_in_ready", 256'(in_ready), 256'(0));
        modelReset();
        @(negedge clk);
        in_valid = '0;
        nreset   = 1'b1;

        // Counter wrap: 17 output transfers on a 4-bit counter leave 1.
        repeat (18) applyStimulus('1, '1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("wrap17", 256'(xfer_count), 256'(1));

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            rv = N'($urandom);
            rm = ($urandom_range(0, 1) == 0) ? '1 : N'($urandom);
            rr = ($urandom_range(0, 3) != 0);
            applyStimulus(rv, rm, rr, 1'b0);
        end
        applyStimulus('0, '0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
